// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
//   state_e : control FSM states (IDLE, SHIFT, DONE)
//   cnt_w() : bit-counter width for a given operand width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold 0..WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor slice built from two half-subtractor cells.
//   a, b   : minuend / subtrahend bit
//   bin    : borrow in
//   d      : difference bit  a ^ b ^ bin
//   bout   : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a  (a),
    .b  (b),
    .d  (d1),
    .bo (b1)
  );

  half_subtractor u_hs1 (
    .a  (d1),
    .b  (bin),
    .d  (d),
    .bo (b2)
  );

  // The two stage borrows are mutually exclusive, so OR merges them.
  assign bout = b1 | b2;

endmodule

// Half-subtractor cell: d = a ^ b, bo = ~a & b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor, LSB first, one bit per clock.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : request, sampled only when not busy (IDLE or DONE)
//   a, b     : minuend / subtrahend, captured on the accepting edge
//   busy     : high while bits are being processed
//   done     : one-cycle pulse, d/bo valid and held until the next result
//   d        : (a - b) mod 2^WIDTH
//   bo       : borrow out of the MSB (a < b)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bo_q, bo_d;

  logic               di;
  logic               bnext;

  // Single datapath slice, fed by the LSBs of the operand shift registers.
  full_subtractor u_fs (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (di),
    .bout (bnext)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    bo_d    = bo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        br_d  = bnext;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {di, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Publish the final bit and borrow directly on DONE entry.
          d_d     = {di, res_q[WIDTH-1:1]};
          bo_d    = bnext;
          state_d = DONE;
        end
      end

      DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Flags are registered from the next state so they track state_q exactly.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors with
// literal expectations plus a transaction-level model compared every cycle.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op keeps busy for W cycles, then the
  // result {bo,d} = {0,a} - {0,b} appears with a one-cycle done.
  int unsigned  m_rem;
  logic         m_done;
  logic [W-1:0] m_d;
  logic         m_bo;
  logic [W-1:0] p_a;
  logic [W-1:0] p_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_d    <= '0;
      m_bo   <= 1'b0;
      p_a    <= '0;
      p_b    <= '0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done      <= 1'b1;
        {m_bo, m_d} <= {1'b0, p_a} - {1'b0, p_b};
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_rem <= W;
        p_a   <= a;
        p_b   <= b;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(busy), 32'(m_rem != 0));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_d",    32'(d),    32'(m_d));
      check("cyc_bo",   32'(bo),   32'(m_bo));
    end
  end

  // Called right after the negedge following the accept edge; returns at the
  // negedge where done is high (or after the cycle budget expires).
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(W));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic ebo);
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    wait_done(name, lat);
    check({name, "_d"},  32'(d),  32'(ed));
    check({name, "_bo"}, 32'(bo), 32'(ebo));
  endtask

  initial begin
    int lat;
    int seen;
    logic [W-1:0] ra, rb;
    logic [W:0]   ref9;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d",    32'(d),    32'd0);
    check("rst_bo",   32'(bo),   32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Basic and wrap-around vectors.
    run_op("t1",      8'd5,   8'd3,   8'h02, 1'b0);
    run_op("t2_neg",  8'd3,   8'd5,   8'hFE, 1'b1);
    run_op("t2_zm1",  8'h00,  8'h01,  8'hFF, 1'b1);
    run_op("t3_eq",   8'hFF,  8'hFF,  8'h00, 1'b0);
    run_op("t3_zero", 8'hA5,  8'h00,  8'hA5, 1'b0);

    // Start while busy is ignored; start held in DONE chains with no IDLE gap.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h40;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t4_ign_d",  32'(d),  32'h2F);
    check("t4_ign_bo", 32'(bo), 32'd0);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    @(negedge clk);
    check("t4_b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("t4_b2b", lat);
    check("t4_b2b_d",  32'(d),  32'hF0);
    check("t4_b2b_bo", 32'(bo), 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h77;
    b     = 8'h22;
    @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_d",    32'(d),    32'd0);
    check("t5_bo",   32'(bo),   32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    run_op("t5_fresh", 8'h30, 8'h0C, 8'h24, 1'b0);

    // Random operands against plain 9-bit arithmetic.
    for (int i = 0; i < 200; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb};
      run_op("rand", ra, rb, ref9[W-1:0], ref9[W]);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
